// File: rtl/rtype_pipe.sv
// rtype_pipe: two-stage R-type execute unit (regfile read + forwarding in S1, registered ALU result in S2)
// clk, rst                 : rising-edge clock, synchronous active-high reset
// in_valid, in_ready       : instruction handshake into S1
// instru                   : MIPS R-format word op|rs|rt|rd|sh|fn
// out_valid, out_ready     : S2 result handshake to the consumer
// Adat, Bdat               : forwarded rs/rt operand values held in S2
// result, zf               : registered ALU result and its zero flag
// rd_out, illegal          : S2 destination register and unsupported-instruction flag
module rtype_pipe #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int SHW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instru,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Adat,
  output logic [DW-1:0] Bdat,
  output logic [DW-1:0] result,
  output logic          zf,
  output logic [AW-1:0] rd_out,
  output logic          illegal
);
  localparam int NREG = 1 << AW;
  logic [DW-1:0] rf_q [NREG];
  logic [31:0] ir_q, ir_d;
  logic s1v_q, s1v_d, s2v_q, s2v_d;
  logic [DW-1:0] a_q, b_q, res_q;
  logic zf_q, ill_q;
  logic [AW-1:0] rd_q;
  logic s2_adv, fwd_ok, we;
  logic [AW-1:0] rs, rt, rd;
  logic [SHW-1:0] sh;
  logic [DW-1:0] a, b, alu;
  logic ill;
  assign s2_adv = !s2v_q | out_ready;
  assign in_ready = !s1v_q | s2_adv;
  assign rs = AW'(ir_q[25:21]);
  assign rt = AW'(ir_q[20:16]);
  assign rd = AW'(ir_q[15:11]);
  assign sh = SHW'(ir_q[10:6]);
  // S2 holds a not-yet-written result; it overrides the regfile for a matching read
  assign fwd_ok = s2v_q & !ill_q & (rd_q != '0);
  assign a = (fwd_ok && rd_q == rs) ? res_q : rf_q[rs];
  assign b = (fwd_ok && rd_q == rt) ? res_q : rf_q[rt];
  assign we = s2v_q & out_ready & !ill_q & (rd_q != '0);
  always_comb begin
    alu = '0;
    ill = 1'b0;
    if (ir_q[31:26] != 6'd0) ill = 1'b1;
    else
      case (ir_q[5:0])
        6'h20, 6'h21: alu = a + b;
        6'h22, 6'h23: alu = a - b;
        6'h24:        alu = a & b;
        6'h25:        alu = a | b;
        6'h26:        alu = a ^ b;
        6'h27:        alu = ~(a | b);
        6'h2A:        alu = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
        6'h2B:        alu = {{(DW-1){1'b0}}, a < b};
        6'h00:        alu = b << sh;
        6'h02:        alu = b >> sh;
        6'h03:        alu = $signed(b) >>> sh;
        default:      ill = 1'b1;
      endcase
  end
  always_comb begin
    s1v_d = (in_valid & in_ready) ? 1'b1 : (s2_adv ? 1'b0 : s1v_q);
    ir_d = (in_valid & in_ready) ? instru : ir_q;
    s2v_d = s2_adv ? s1v_q : s2v_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1v_q <= 1'b0;
      s2v_q <= 1'b0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      zf_q <= 1'b0;
      rd_q <= '0;
      ill_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      s1v_q <= s1v_d;
      ir_q <= ir_d;
      s2v_q <= s2v_d;
      if (s2_adv & s1v_q) begin
        a_q <= a;
        b_q <= b;
        res_q <= alu;
        zf_q <= (alu == '0);
        rd_q <= rd;
        ill_q <= ill;
      end
      if (we) rf_q[rd_q] <= res_q;
    end
  end
  assign out_valid = s2v_q;
  assign Adat = a_q;
  assign Bdat = b_q;
  assign result = res_q;
  assign zf = zf_q;
  assign rd_out = rd_q;
  assign illegal = ill_q;
endmodule
